port_tx_ctrl: RTL

// Output-port drain engine of the switch: reads packet bytes from one egress fifo
// (W_WIDTH-bit words) and transmits them on a valid/ready byte stream toward the port.

---
 rtl/port_tx_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/port_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : port_tx_ctrl
// Description : Output-port drain engine. Reads packet bytes from an egress
//               fifo with one-cycle read latency into a 2-entry skid buffer
//               and streams them on a valid/ready byte interface. Packets are
//               framed as DA, LEN, then LEN payload bytes; sop/eop mark the
//               first/last byte and pkt_cnt counts completed packets.
// Ports       : clk         clock (posedge)
//               rst         synchronous active-high reset
//               fifo_empty  egress fifo empty flag
//               fifo_data   fifo read data, valid the cycle after fifo_rd_en
//               fifo_rd_en  fifo read strobe (combinational)
//               tx_ready    downstream accepts a byte this cycle
//               tx_valid    tx_data holds a byte
//               tx_data     output byte (skid buffer head)
//               tx_sop      tx_data is the DA byte of a packet
//               tx_eop      tx_data is the last byte of a packet
//               pkt_cnt     packets fully transmitted since reset (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module port_tx_ctrl #(
    parameter int W_WIDTH   = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fifo_empty,
    input  logic [W_WIDTH-1:0]   fifo_data,
    output logic                 fifo_rd_en,
    input  logic                 tx_ready,
    output logic                 tx_valid,
    output logic [W_WIDTH-1:0]   tx_data,
    output logic                 tx_sop,
    output logic                 tx_eop,
    output logic [CNT_WIDTH-1:0] pkt_cnt
);

    // Framing states
    localparam logic [1:0] c_S_HDR = 2'd0;
    localparam logic [1:0] c_S_LEN = 2'd1;
    localparam logic [1:0] c_S_PAY = 2'd2;

    logic [1:0]           r_occ;        // bytes held in the skid buffer
    logic                 r_inflight;   // a fifo read issued last cycle
    logic [W_WIDTH-1:0]   r_buf [0:1];  // r_buf[0] is the head
    logic [1:0]           r_state;
    logic [W_WIDTH-1:0]   r_remaining;  // payload bytes still to send
    logic [CNT_WIDTH-1:0] r_pkt_cnt;

    logic                 w_pop;
    logic [2:0]           w_level;
    logic                 w_wr_idx;
    logic [W_WIDTH-1:0]   w_head;

    assign w_head = r_buf[0];
    assign w_pop  = (r_occ != 2'd0) & tx_ready;

    // Occupancy that will remain after this cycle's pop, counting the byte
    // already on its way from the fifo. Reading only when this is below 2
    // guarantees the returning byte always finds a free slot.
    assign w_level    = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign fifo_rd_en = !rst & !fifo_empty & (w_level < 3'd2);

    // Tail slot for the arriving byte, taking the simultaneous pop into
    // account: it lands in slot 1 only if one byte stays ahead of it.
    assign w_wr_idx = (r_occ == 2'd2) | ((r_occ == 2'd1) & !w_pop);

    // ------------------------------------------------------------------
    // Skid buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ      <= 2'd0;
            r_inflight <= 1'b0;
            r_buf[0]   <= '0;
            r_buf[1]   <= '0;
        end else begin
            r_inflight <= fifo_rd_en;
            r_occ      <= r_occ - {1'b0, w_pop} + {1'b0, r_inflight};
            if (w_pop) begin
                r_buf[0] <= r_buf[1];
            end
            // Placed after the shift so a same-cycle write to slot 0 wins.
            if (r_inflight) begin
                r_buf[w_wr_idx] <= fifo_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Framing FSM: advances only when a byte is actually accepted
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_S_HDR;
            r_remaining <= '0;
            r_pkt_cnt   <= '0;
        end else if (w_pop) begin
            case (r_state)
                c_S_HDR: begin
                    r_state <= c_S_LEN;
                end
                c_S_LEN: begin
                    if (w_head == '0) begin
                        r_state   <= c_S_HDR;
                        r_pkt_cnt <= r_pkt_cnt + CNT_WIDTH'(1);
                    end else begin
                        r_remaining <= w_head;
                        r_state     <= c_S_PAY;
                    end
                end
                c_S_PAY: begin
                    r_remaining <= r_remaining - W_WIDTH'(1);
                    if (r_remaining == W_WIDTH'(1)) begin
                        r_state   <= c_S_HDR;
                        r_pkt_cnt <= r_pkt_cnt + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    r_state <= c_S_HDR;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all derived from registered state, so they hold while stalled
    // ------------------------------------------------------------------
    assign tx_valid = (r_occ != 2'd0);
    assign tx_data  = w_head;
    assign tx_sop   = tx_valid & (r_state == c_S_HDR);
    assign tx_eop   = tx_valid &
                      (((r_state == c_S_LEN) & (w_head == '0)) |
                       ((r_state == c_S_PAY) & (r_remaining == W_WIDTH'(1))));
    assign pkt_cnt  = r_pkt_cnt;

endmodule
`default_nettype wire
